// File: rtl/shazam_pkg.sv
// Shared definitions for the shazam front end: ADC geometry, the
// conditioning FSM state type and the output saturation helper.
package shazam_pkg;

  localparam int ADC_W    = 12;
  localparam int MIDSCALE = 2048;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RUN    = 2'd2
  } state_t;

  // Saturate a signed value into [0, hi].
  function automatic logic signed [31:0] sat_range(input logic signed [31:0] v,
                                                   input logic signed [31:0] hi);
    if (v < 0)
      return 32'sd0;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage

// File: rtl/dc_tracker.sv
// Exponential running-mean DC estimate: dc_acc tracks avg with alpha = 2^-DC_SHIFT.
// dc is the estimate before the update applied on the current upd edge.
module dc_tracker
  import shazam_pkg::*;
#(
  parameter int DATA_W   = ADC_W,
  parameter int DC_SHIFT = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              upd,
  input  logic [DATA_W-1:0] avg,
  output logic [DATA_W-1:0] dc
);

  localparam int ACC_W = DATA_W + DC_SHIFT + 1;
  localparam logic signed [ACC_W-1:0] ACC_INIT = $signed(ACC_W'(1) << (DATA_W - 1 + DC_SHIFT));

  logic signed [ACC_W-1:0] dc_acc;
  logic signed [ACC_W-1:0] avg_x;
  logic signed [ACC_W-1:0] dc_x;

  assign dc    = DATA_W'(dc_acc >>> DC_SHIFT);
  assign avg_x = $signed(ACC_W'(avg));
  assign dc_x  = $signed(ACC_W'(dc));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      dc_acc <= ACC_INIT;
    else if (upd)
      dc_acc <= dc_acc + avg_x - dc_x;
  end

endmodule

// File: rtl/adc_decimator.sv
// Boxcar decimator with DC removal ahead of shazam_core: averages 2^DECIM_LOG2
// raw codes, subtracts the tracked DC, re-centres to midscale and saturates.
module adc_decimator
  import shazam_pkg::*;
#(
  parameter int DATA_W        = ADC_W,
  parameter int DECIM_LOG2    = 3,
  parameter int SETTLE_GROUPS = 16,
  parameter int DC_SHIFT      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DATA_W-1:0] raw_data,
  input  logic              raw_valid,
  output logic [DATA_W-1:0] adc_data,
  output logic              adc_data_valid,
  output logic              clip,
  output logic              busy
);

  localparam int ACC_W = DATA_W + DECIM_LOG2;
  localparam int SC_W  = $clog2(SETTLE_GROUPS + 2);
  localparam logic signed [DATA_W+1:0] MID_S = (DATA_W + 2)'(2 ** (DATA_W - 1));
  localparam logic signed [31:0] OUT_MAX = (2 ** DATA_W) - 1;

  state_t                  state;
  logic [ACC_W-1:0]        acc;
  logic [DECIM_LOG2-1:0]   grp_cnt;
  logic [SC_W-1:0]         settle_cnt;

  logic                    take;
  logic                    grp_done;
  logic [ACC_W-1:0]        sum;
  logic [DATA_W-1:0]       avg;
  logic [DATA_W-1:0]       dc;
  logic signed [DATA_W+1:0] y;
  logic signed [31:0]      y_int;
  logic signed [31:0]      y_sat;
  logic                    y_clipped;

  assign take     = (state != IDLE) && raw_valid;
  assign grp_done = take && (grp_cnt == {DECIM_LOG2{1'b1}});
  assign sum      = acc + ACC_W'(raw_data);
  assign avg      = DATA_W'(sum >> DECIM_LOG2);

  dc_tracker #(
    .DATA_W  (DATA_W),
    .DC_SHIFT(DC_SHIFT)
  ) u_dc_tracker (
    .clk  (clk),
    .reset(reset),
    .upd  (grp_done),
    .avg  (avg),
    .dc   (dc)
  );

  // Re-centred sample, then saturation into the unsigned output range
  assign y         = $signed({2'b00, avg}) - $signed({2'b00, dc}) + MID_S;
  assign y_int     = 32'(y);
  assign y_sat     = sat_range(y_int, OUT_MAX);
  assign y_clipped = (y_sat != y_int);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      busy           <= 1'b0;
      acc            <= '0;
      grp_cnt        <= '0;
      settle_cnt     <= '0;
      adc_data       <= '0;
      adc_data_valid <= 1'b0;
      clip           <= 1'b0;
    end else begin
      adc_data_valid <= 1'b0;
      if (grp_done && state == RUN) begin
        adc_data_valid <= 1'b1;
        adc_data       <= DATA_W'(y_sat);
        if (y_clipped)
          clip <= 1'b1;
      end

      if (take) begin
        acc     <= grp_done ? '0 : sum;
        grp_cnt <= grp_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= (SETTLE_GROUPS == 0) ? RUN : SETTLE;
            busy  <= 1'b1;
          end
        end
        SETTLE: begin
          if (grp_done) begin
            settle_cnt <= settle_cnt + 1'b1;
            if (settle_cnt == SC_W'(SETTLE_GROUPS - 1))
              state <= RUN;
          end
        end
        RUN: ;
        default: state <= IDLE;
      endcase

      // A low start wins over everything above except the group already processed
      if (!start) begin
        state      <= IDLE;
        busy       <= 1'b0;
        acc        <= '0;
        grp_cnt    <= '0;
        settle_cnt <= '0;
      end
    end
  end

endmodule
